// File: rtl/dds_freq_meter_pkg.sv
// Shared definitions for the reciprocal-gate frequency meter.
package dds_freq_meter_pkg;

    // Measurement sequencer states
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StArm  = 2'd1,
        StGate = 2'd2,
        StDone = 2'd3
    } meter_state_e;

    // 1 s minimum gate and 2 s abort limit at a 50 MHz system clock
    localparam int unsigned DefGateCycles    = 50_000_000;
    localparam int unsigned DefTimeoutCycles = 100_000_000;

endpackage

// File: rtl/dds_freq_meter_if.sv
// Request/result bundle between a measurement client and the meter.
interface dds_freq_meter_if #(
    parameter int unsigned CNT_W = 32
);
    logic             start;
    logic             busy;
    logic             valid;
    logic             timeout;
    logic [CNT_W-1:0] edge_cnt;
    logic [CNT_W-1:0] clk_cnt;

    // Client side: issues start, consumes results
    modport master (
        output start,
        input  busy,
        input  valid,
        input  timeout,
        input  edge_cnt,
        input  clk_cnt
    );

    // Meter side
    modport slave (
        input  start,
        output busy,
        output valid,
        output timeout,
        output edge_cnt,
        output clk_cnt
    );
endinterface

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer plus rising-edge pulse for an asynchronous input.
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic rise_o
);
    // sync_q[0], sync_q[1] form the synchronizer; sync_q[2] is the previous sample
    logic [2:0] sync_q, sync_d;
    // fill_q[i] marks sync_q[i] as holding a real sample since reset, so a line
    // already high when reset releases is not mistaken for a 0->1 transition
    logic [2:0] fill_q, fill_d;

    // Next-state: shift the input and the fill markers along the chain
    always_comb begin
        sync_d = {sync_q[1:0], sig_i};
        fill_d = {fill_q[1:0], 1'b1};
    end

    // Synchronizer and fill registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 3'b000;
            fill_q <= 3'b000;
        end else begin
            sync_q <= sync_d;
            fill_q <= fill_d;
        end
    end

    assign rise_o = fill_q[2] & sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/dds_freq_meter.sv
// Reciprocal frequency meter: counts whole sig_in periods (Nx) and clk cycles (Ns)
// over a gate that opens and closes on sig_in rising edges. f_sig = f_clk * Nx / Ns.
module dds_freq_meter
    import dds_freq_meter_pkg::*;
#(
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned GATE_CYCLES    = DefGateCycles,
    parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           sig_in,
    dds_freq_meter_if.slave meas
);
    localparam logic [CNT_W-1:0] GateLim    = CNT_W'(GATE_CYCLES);
    localparam logic [CNT_W-1:0] TmoLim     = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] ArmLastCnt = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] One        = CNT_W'(1);

    logic rise;

    sync_edge_det u_sync_edge_det (
        .clk    (clk),
        .rst    (rst),
        .sig_i  (sig_in),
        .rise_o (rise)
    );

    meter_state_e     state_q, state_d;
    logic [CNT_W-1:0] clk_ctr_q, clk_ctr_d;     // cycles since opening edge
    logic [CNT_W-1:0] edge_ctr_q, edge_ctr_d;   // edges seen inside the gate
    logic [CNT_W-1:0] tmo_ctr_q, tmo_ctr_d;     // cycles spent waiting in ARM
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic             timeout_q, timeout_d;

    // Sequencer next-state, counter updates and result capture
    always_comb begin
        state_d    = state_q;
        clk_ctr_d  = clk_ctr_q;
        edge_ctr_d = edge_ctr_q;
        tmo_ctr_d  = tmo_ctr_q;
        edge_cnt_d = edge_cnt_q;
        clk_cnt_d  = clk_cnt_q;
        timeout_d  = timeout_q;

        case (state_q)
            StIdle: begin
                if (meas.start) begin
                    state_d    = StArm;
                    clk_ctr_d  = '0;
                    edge_ctr_d = '0;
                    tmo_ctr_d  = '0;
                end
            end
            StArm: begin
                if (rise) begin
                    // Opening edge is cycle t0; the gate's first cycle is t0 + 1
                    state_d    = StGate;
                    clk_ctr_d  = One;
                    edge_ctr_d = '0;
                end else if (tmo_ctr_q == ArmLastCnt) begin
                    state_d    = StDone;
                    timeout_d  = 1'b1;
                    edge_cnt_d = '0;
                    clk_cnt_d  = '0;
                end else begin
                    tmo_ctr_d = tmo_ctr_q + One;
                end
            end
            StGate: begin
                if (rise && (clk_ctr_q >= GateLim)) begin
                    // Closing edge completes the last period, so it is counted
                    state_d    = StDone;
                    timeout_d  = 1'b0;
                    edge_cnt_d = edge_ctr_q + One;
                    clk_cnt_d  = clk_ctr_q;
                end else if (clk_ctr_q == TmoLim) begin
                    // TmoLim > GateLim, so any edge here would have closed above
                    state_d    = StDone;
                    timeout_d  = 1'b1;
                    edge_cnt_d = edge_ctr_q;
                    clk_cnt_d  = clk_ctr_q;
                end else begin
                    clk_ctr_d  = clk_ctr_q + One;
                    edge_ctr_d = edge_ctr_q + CNT_W'(rise);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, internal counters and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            clk_ctr_q  <= '0;
            edge_ctr_q <= '0;
            tmo_ctr_q  <= '0;
            edge_cnt_q <= '0;
            clk_cnt_q  <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_ctr_q  <= clk_ctr_d;
            edge_ctr_q <= edge_ctr_d;
            tmo_ctr_q  <= tmo_ctr_d;
            edge_cnt_q <= edge_cnt_d;
            clk_cnt_q  <= clk_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign meas.busy     = (state_q != StIdle);
    assign meas.valid    = (state_q == StDone);
    assign meas.timeout  = timeout_q;
    assign meas.edge_cnt = edge_cnt_q;
    assign meas.clk_cnt  = clk_cnt_q;

endmodule

// File: tb/tb_dds_freq_meter.sv
// Randomized bench for dds_freq_meter against a closed-form period/gate model.
module tb_dds_freq_meter;
    localparam int unsigned CntW    = 32;
    localparam int unsigned Gate    = 100;
    localparam int unsigned Timeout = 300;

    logic clk;
    logic rst;
    logic sig_in;

    dds_freq_meter_if #(.CNT_W(CntW)) meas_if ();

    dds_freq_meter #(
        .CNT_W          (CntW),
        .GATE_CYCLES    (Gate),
        .TIMEOUT_CYCLES (Timeout)
    ) u_dut (
        .clk    (clk),
        .rst    (rst),
        .sig_in (sig_in),
        .meas   (meas_if)
    );

    int n_checks = 0;
    int n_errors = 0;
    int gen_period = 0;   // 0 holds sig_in low

    // Expected results of the most recent delivered measurement
    longint prev_edge = 0;
    longint prev_clk  = 0;
    longint prev_tmo  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Square-wave source; restarts its phase when the period changes
    initial begin
        int ph;
        int last;
        ph = 0;
        last = 0;
        sig_in = 1'b0;
        forever begin
            @(negedge clk);
            if (gen_period != last) begin
                last = gen_period;
                ph = 0;
            end
            if (gen_period == 0) begin
                sig_in = 1'b0;
            end else begin
                sig_in = (ph < gen_period / 2);
                ph = (ph + 1 >= gen_period) ? 0 : ph + 1;
            end
        end
    end

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Gate closes on the first edge at or beyond Gate cycles after the opening edge
    function automatic void model_expect(input int p, output longint e, output longint c,
                                         output longint t);
        longint nx;
        if (p == 0) begin
            e = 0; c = 0; t = 1;
        end else begin
            nx = (Gate + p - 1) / p;
            if (nx * p <= Timeout) begin
                e = nx; c = nx * p; t = 0;
            end else begin
                e = (Timeout - 1) / p; c = Timeout; t = 1;
            end
        end
    endfunction

    task automatic measure(input int p, input bit restart_mid, input string tag);
        longint e, c, t;
        int n;
        bit got;
        int hold_bad;
        int extra;
        model_expect(p, e, c, t);
        gen_period = p;
        repeat (5 + $urandom_range(0, p)) @(negedge clk);
        meas_if.start = 1'b1;
        @(posedge clk);                     // ARM entered here
        @(negedge clk);
        meas_if.start = 1'b0;
        check_eq({tag, "_busy"}, meas_if.busy, 1);
        n = 0;
        got = 1'b0;
        hold_bad = 0;
        while (!got && n < 1000) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            meas_if.start = restart_mid && (n == 50);
            if (meas_if.valid) begin
                got = 1'b1;
            end else if (meas_if.edge_cnt != prev_edge || meas_if.clk_cnt != prev_clk ||
                         meas_if.timeout != prev_tmo) begin
                hold_bad++;
            end
        end
        meas_if.start = 1'b0;
        check_eq({tag, "_valid_seen"}, got, 1);
        if (got) begin
            check_eq({tag, "_edge_cnt"}, meas_if.edge_cnt, e);
            check_eq({tag, "_clk_cnt"}, meas_if.clk_cnt, c);
            check_eq({tag, "_timeout"}, meas_if.timeout, t);
            if (p == 0) check_eq({tag, "_arm_cycles"}, n, Timeout);
        end
        check_eq({tag, "_hold"}, hold_bad, 0);
        @(negedge clk);
        check_eq({tag, "_valid_pulse"}, meas_if.valid, 0);
        check_eq({tag, "_idle"}, meas_if.busy, 0);
        if (restart_mid) begin
            extra = 0;
            repeat (200) begin
                @(negedge clk);
                if (meas_if.valid) extra++;
            end
            check_eq({tag, "_extra_valid"}, extra, 0);
        end
        prev_edge = e;
        prev_clk  = c;
        prev_tmo  = t;
    endtask

    task automatic reset_mid_gate();
        int extra;
        gen_period = 10;
        repeat (8) @(negedge clk);
        meas_if.start = 1'b1;
        @(negedge clk);
        meas_if.start = 1'b0;
        repeat (63) @(negedge clk);          // opening edge plus about 50 gate cycles
        check_eq("rstmid_busy_before", meas_if.busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rstmid_busy", meas_if.busy, 0);
        check_eq("rstmid_valid", meas_if.valid, 0);
        check_eq("rstmid_timeout", meas_if.timeout, 0);
        check_eq("rstmid_edge_cnt", meas_if.edge_cnt, 0);
        check_eq("rstmid_clk_cnt", meas_if.clk_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        extra = 0;
        repeat (150) begin
            @(negedge clk);
            if (meas_if.valid || meas_if.busy) extra++;
        end
        check_eq("rstmid_no_result", extra, 0);
        prev_edge = 0;
        prev_clk  = 0;
        prev_tmo  = 0;
    endtask

    initial begin
        rst = 1'b1;
        meas_if.start = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("reset_busy", meas_if.busy, 0);
        check_eq("reset_valid", meas_if.valid, 0);
        check_eq("reset_timeout", meas_if.timeout, 0);
        check_eq("reset_edge_cnt", meas_if.edge_cnt, 0);
        check_eq("reset_clk_cnt", meas_if.clk_cnt, 0);
        rst = 1'b0;
        @(negedge clk);

        measure(10, 1'b0, "p10");
        measure(7, 1'b0, "p7");
        measure(0, 1'b0, "stuck_low");
        measure(10, 1'b1, "p10_restart");
        reset_mid_gate();
        measure(10, 1'b0, "p10_after_rst");
        measure(200, 1'b0, "p200");
        for (int i = 0; i < 8; i++) begin
            measure($urandom_range(2, 250), 1'b0, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
